// File: rtl/zeroheti_pkg.sv
// Shared definitions for the zeroheti debug/data OBI arbitration path.
package zeroheti_pkg;

    // Managers sharing the data port: core data port (0) and debug SBA master (1).
    localparam int unsigned DbgArbNumReq = 2;

    // Identifier of an upstream manager, as stored in the outstanding-ID FIFO.
    typedef logic [$clog2(DbgArbNumReq)-1:0] arb_id_t;

endpackage

// File: rtl/zeroheti_id_fifo.sv
// In-order FIFO of manager IDs for outstanding OBI transactions.
// Push/pop requests that would overflow or underflow are ignored.
module zeroheti_id_fifo
    import zeroheti_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter int unsigned IdWidth = $bits(arb_id_t)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push,
    input  logic               pop,
    input  logic [IdWidth-1:0] data_i,
    output logic [IdWidth-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [CntW-1:0] count_r;
    logic            push_s;
    logic            pop_s;

    assign full_o  = (count_r == CntW'(Depth));
    assign empty_o = (count_r == CntW'(0));
    assign push_s  = push & ~full_o;
    assign pop_s   = pop & ~empty_o;

    // Occupancy counter: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= CntW'(0);
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    generate
        if (Depth == 1) begin : g_single
            logic [IdWidth-1:0] slot_r;

            // Single-entry storage: no pointers are needed.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    slot_r <= {IdWidth{1'b0}};
                end else if (push_s) begin
                    slot_r <= data_i;
                end else begin
                    slot_r <= slot_r;
                end
            end

            assign head_o = slot_r;
        end else begin : g_ring
            localparam int unsigned PtrW = $clog2(Depth);

            logic [IdWidth-1:0] mem_r [Depth];
            logic [PtrW-1:0]    wptr_r;
            logic [PtrW-1:0]    rptr_r;

            // Read/write pointers wrap naturally at the power-of-two depth.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wptr_r <= PtrW'(0);
                    rptr_r <= PtrW'(0);
                end else begin
                    if (push_s) begin
                        wptr_r <= wptr_r + PtrW'(1);
                    end else begin
                        wptr_r <= wptr_r;
                    end
                    if (pop_s) begin
                        rptr_r <= rptr_r + PtrW'(1);
                    end else begin
                        rptr_r <= rptr_r;
                    end
                end
            end

            // Entry storage, cleared so the head is never undefined.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int unsigned k = 0; k < Depth; k++) begin
                        mem_r[k] <= {IdWidth{1'b0}};
                    end
                end else if (push_s) begin
                    mem_r[wptr_r] <= data_i;
                end else begin
                    mem_r[wptr_r] <= mem_r[wptr_r];
                end
            end

            assign head_o = mem_r[rptr_r];
        end
    endgenerate

endmodule

// File: rtl/zeroheti_obi_arb.sv
// Round-robin arbiter sharing one OBI memory-side port between NumReq
// managers. Responses are routed back in order through an ID FIFO.
module zeroheti_obi_arb
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumReq         = DbgArbNumReq,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     s_req_i,
    output logic [NumReq-1:0]                     s_gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]      s_addr_i,
    input  logic [NumReq-1:0]                     s_we_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]    s_be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]      s_wdata_i,
    output logic [NumReq-1:0]                     s_rvalid_o,
    output logic [DataWidth-1:0]                  s_rdata_o,
    output logic                                  s_err_o,
    output logic                                  m_req_o,
    input  logic                                  m_gnt_i,
    output logic [AddrWidth-1:0]                  m_addr_o,
    output logic                                  m_we_o,
    output logic [DataWidth/8-1:0]                m_be_o,
    output logic [DataWidth-1:0]                  m_wdata_o,
    input  logic                                  m_rvalid_i,
    input  logic [DataWidth-1:0]                  m_rdata_i,
    input  logic                                  m_err_i,
    output logic                                  protocol_err_o
);

    localparam int unsigned IdW = $clog2(NumReq);

    logic [IdW-1:0] prio_r;
    logic [IdW-1:0] winner_s;
    logic           found_s;
    logic           handshake_s;
    logic           resp_ok_s;
    logic [IdW-1:0] head_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           protocol_err_r;

    // Index 'off' positions after 'base', wrapping at NumReq.
    function automatic logic [IdW-1:0] rr_next(input logic [IdW-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IdW'(sum % NumReq);
    endfunction

    // Winner: first requester at or after the priority pointer, with wrap.
    always_comb begin
        winner_s = prio_r;
        found_s  = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found_s && s_req_i[rr_next(prio_r, i)]) begin
                found_s  = 1'b1;
                winner_s = rr_next(prio_r, i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // A full ID FIFO blocks new requests even if it pops this cycle.
    assign m_req_o     = (|s_req_i) & ~fifo_full_s & ~rst_i;
    assign handshake_s = m_req_o & m_gnt_i;
    assign m_addr_o    = s_addr_i[winner_s];
    assign m_we_o      = s_we_i[winner_s];
    assign m_be_o      = s_be_i[winner_s];
    assign m_wdata_o   = s_wdata_i[winner_s];

    // Grant goes only to the current winner, in the downstream grant cycle.
    always_comb begin
        s_gnt_o = {NumReq{1'b0}};
        if (handshake_s) begin
            s_gnt_o[winner_s] = 1'b1;
        end else begin
            s_gnt_o = {NumReq{1'b0}};
        end
    end

    // Priority moves past the winner only on an accepted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_r <= IdW'(0);
        end else if (handshake_s) begin
            prio_r <= rr_next(winner_s, 1);
        end else begin
            prio_r <= prio_r;
        end
    end

    zeroheti_id_fifo #(
        .Depth   (MaxOutstanding),
        .IdWidth (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (handshake_s),
        .pop     (resp_ok_s),
        .data_i  (winner_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Responses are only routed when a transaction is actually outstanding.
    assign resp_ok_s = m_rvalid_i & ~fifo_empty_s & ~rst_i;
    assign s_rdata_o = m_rdata_i;
    assign s_err_o   = m_err_i;

    // Response demux to the manager at the head of the ID FIFO.
    always_comb begin
        s_rvalid_o = {NumReq{1'b0}};
        if (resp_ok_s) begin
            s_rvalid_o[head_s] = 1'b1;
        end else begin
            s_rvalid_o = {NumReq{1'b0}};
        end
    end

    // Sticky flag for a response that had no matching outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            protocol_err_r <= 1'b0;
        end else if (m_rvalid_i && fifo_empty_s) begin
            protocol_err_r <= 1'b1;
        end else begin
            protocol_err_r <= protocol_err_r;
        end
    end

    assign protocol_err_o = protocol_err_r;

endmodule
